sram_rd_arbiter: RTL and testbench
==================================

Name: sram_rd_arbiter

Overview:
Two-port read arbiter and sequencer for the 1024x8 read-only SRAM macro, which has an asynchronous read path with a 4 ns output delay.
It accepts read requests from two independent requesters and grants them round-robin. It drives the SRAM address, waits a fixed number of clocks for the macro output to settle, then registers the data and returns it to the granted requester with a one-cycle valid pulse.
It sits between the SRAM instance and the fetch/lookup logic that shares it.

Parameters:
ADDR_W, 10, SRAM address width (1024 words)
DATA_W, 8, SRAM word width
WAIT_CYCLES, 1, clocks between address launch and data capture; legal range 1..15; must cover the 4 ns macro delay plus routing
CNT_W, 4, wait counter width; must hold WAIT_CYCLES

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 read request; held with addr0 until rvalid0
addr0  input  ADDR_W  port 0 read address
req1  input  1  port 1 read request; held with addr1 until rvalid1
addr1  input  ADDR_W  port 1 read address
rdata  output  DATA_W  registered read data, shared by both ports
rvalid0  output  1  one-cycle pulse: rdata belongs to port 0
rvalid1  output  1  one-cycle pulse: rdata belongs to port 1
busy  output  1  high in every state except IDLE
mem_addr  output  ADDR_W  address to the SRAM ReadAddress input
mem_rdata  input  DATA_W  SRAM ReadBus

Behaviour:
- Reset (asynchronous, rst_n low): outputs, registers and the round-robin pointer are cleared.
  - State = IDLE.
  - mem_addr = 0, rdata = 0, rvalid0 = rvalid1 = 0, busy = 0.
  - Priority pointer favours port 0.
- All outputs are registered; no combinational path from req/addr to any output.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req high: select a winner, load mem_addr with the winner's address, record the winner, load cnt = WAIT_CYCLES, go to WAIT.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port indicated by the pointer wins.
  - On every grant the pointer moves to the other port, giving strict alternation under sustained contention.
- WAIT:
  - cnt decrements each clock while mem_addr is held.
  - On the edge where cnt==1: rdata <= mem_rdata, assert rvalid of the recorded winner, go to RESP.
  - Requests arriving during WAIT are ignored until IDLE.
- RESP:
  - rvalid is high for exactly this one cycle; the requester must drop req at the following edge.
  - Next state is IDLE; rvalid clears.
- Latency:
  - Request sampled in IDLE at edge E0; data captured at edge E0+WAIT_CYCLES; rvalid high in the following cycle.
  - Throughput is one read per WAIT_CYCLES+2 clocks.
- Data and address hold:
  - rdata holds its last captured value until the next capture, so it is valid whenever rvalid is high.
  - mem_addr holds its last value in IDLE; it changes only when a request is accepted.
- Requester protocol: a requester that drops req before its rvalid still receives its response; the transaction is not cancelled.
- Reset mid-operation: an in-flight read is discarded, no rvalid is produced, and the block returns to the reset values above.
- Address range: no wrap or range checking; all ADDR_W-bit addresses are legal, including 10'h3FF.
- At most one rvalid is high in any cycle.

Test Plan:
- Single read: clk 10 ns, WAIT_CYCLES=1, mem[10'h005]=8'hA5; req0 with addr0=10'h005 -> mem_addr=5 after the grant edge; rvalid0 pulses 1 cycle with rdata=8'hA5 two cycles after the request is sampled; busy high for 2 cycles; rvalid1 stays 0.
- Contention: req0 (addr 10'h001, mem=8'h11) and req1 (addr 10'h3FF, mem=8'hFF) both high from reset -> port 0 served first (rvalid0, 8'h11), then port 1 (rvalid1, 8'hFF); both held high for 4 more requests -> grants alternate strictly 0,1,0,1.
- Wait setting: WAIT_CYCLES=3, address settles 4 ns after launch -> rdata captured on the 3rd edge after the grant, equal to the stored value; never a stale value.
- Back-to-back on one port: req0 reasserted the cycle after IDLE, with addresses 0,1,2,3 holding 8'h00..8'h03 -> four rvalid0 pulses exactly WAIT_CYCLES+2 cycles apart, data 00,01,02,03 in order.
- Reset mid-read: rst_n pulsed low during WAIT -> no rvalid, mem_addr=0, busy=0 immediately (asynchronous); after release, simultaneous req0/req1 -> port 0 wins.
- Late req drop: req1 dropped during WAIT -> rvalid1 still pulses with the correct data; FSM returns to IDLE and stays idle.

Source files
------------

// File: rtl/sram_rd_arbiter.sv
// Round-robin two-port read arbiter/sequencer for an asynchronous-read SRAM macro.
// Grants one request, holds the address WAIT_CYCLES clocks, captures data and pulses rvalid.
module sram_rd_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;     // recorded winner: 0 = port 0, 1 = port 1
    logic               ptr_q, ptr_d;     // 1 = port 1 favoured on contention
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic               busy_q, busy_d;
    logic               grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_q      <= 1'b0;
            ptr_q      <= 1'b0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            busy_q     <= busy_d;
        end
    end

    // Port 1 wins when it is the only requester or when the pointer favours it.
    assign grant1 = req1 & (~req0 | ptr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    win_d      = grant1;
                    ptr_d      = ~grant1;
                    mem_addr_d = grant1 ? addr1 : addr0;
                    cnt_d      = CNT_W'(WAIT_CYCLES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d   = mem_rdata;
                    rvalid0_d = ~win_q;
                    rvalid1_d = win_q;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign rdata    = rdata_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign busy     = busy_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed bench for sram_rd_arbiter: vector table plus hand sequences for reset,
// back-to-back reads and a WAIT_CYCLES=3 instance, against a 4 ns-delay SRAM model.
module tb_sram_rd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [9:0] addr0, addr1, mem_addr;
    logic [7:0] rdata, mem_rdata;
    logic       rvalid0, rvalid1, busy;

    logic       req0_3, req1_3;
    logic [9:0] addr0_3, addr1_3, mem_addr_3;
    logic [7:0] rdata_3, mem_rdata_3;
    logic       rvalid0_3, rvalid1_3, busy_3;

    logic [7:0] mem [1024];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sram_rd_arbiter #(.ADDR_W(10), .DATA_W(8), .WAIT_CYCLES(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1), .busy(busy),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata));

    sram_rd_arbiter #(.ADDR_W(10), .DATA_W(8), .WAIT_CYCLES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req0(req0_3), .addr0(addr0_3), .req1(req1_3), .addr1(addr1_3),
        .rdata(rdata_3), .rvalid0(rvalid0_3), .rvalid1(rvalid1_3), .busy(busy_3),
        .mem_addr(mem_addr_3), .mem_rdata(mem_rdata_3));

    // Asynchronous SRAM read path: data follows the address after 4 ns.
    always begin
        @(mem_addr);
        #4 mem_rdata = mem[mem_addr];
    end
    always begin
        @(mem_addr_3);
        #4 mem_rdata_3 = mem[mem_addr_3];
    end

    typedef struct {
        logic       r0;
        logic [9:0] a0;
        logic       r1;
        logic [9:0] a1;
        logic       v0;
        logic       v1;
        logic [7:0] rd;
        logic       bsy;
        logic [9:0] ma;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r0, logic [9:0] a0, logic r1, logic [9:0] a1,
                                logic v0, logic v1, logic [7:0] rd, logic bsy, logic [9:0] ma);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
        v.v0 = v0; v.v1 = v1; v.rd = rd; v.bsy = bsy; v.ma = ma;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic v0, input logic v1,
                            input logic [7:0] rd, input logic bsy, input logic [9:0] ma);
        check({tag, ".rvalid0"}, 32'(rvalid0), 32'(v0));
        check({tag, ".rvalid1"}, 32'(rvalid1), 32'(v1));
        check({tag, ".rdata"}, 32'(rdata), 32'(rd));
        check({tag, ".busy"}, 32'(busy), 32'(bsy));
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(ma));
    endtask

    initial begin
        logic [7:0] prev_d, d;
        logic [9:0] a;
        logic       port;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[10'h000] = 8'h00; mem[10'h001] = 8'h11; mem[10'h002] = 8'h02; mem[10'h003] = 8'h03;
        mem[10'h005] = 8'hA5; mem[10'h3FF] = 8'hFF; mem[10'h0C3] = 8'h3C; mem[10'h2A5] = 8'h5C;
        mem_rdata = mem[0]; mem_rdata_3 = mem[0];
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
        req0_3 = 0; req1_3 = 0; addr0_3 = '0; addr1_3 = '0;
        rst_n = 1'b0;

        // Contention from reset: both held high, grants alternate 0,1,0,1,0,1.
        prev_d = 8'h00;
        for (int g = 0; g < 6; g++) begin
            port = g[0];
            a    = port ? 10'h3FF : 10'h001;
            d    = port ? 8'hFF : 8'h11;
            tbl.push_back(mk(1, 10'h001, 1, 10'h3FF, 0, 0, prev_d, 1, a));
            tbl.push_back(mk(1, 10'h001, 1, 10'h3FF, !port, port, d, 1, a));
            tbl.push_back(mk(1, 10'h001, 1, 10'h3FF, 0, 0, d, 0, a));
            prev_d = d;
        end
        // Single read on port 0, request dropped after its rvalid.
        tbl.push_back(mk(1, 10'h005, 0, 10'h000, 0, 0, 8'hFF, 1, 10'h005));
        tbl.push_back(mk(1, 10'h005, 0, 10'h000, 1, 0, 8'hA5, 1, 10'h005));
        tbl.push_back(mk(1, 10'h005, 0, 10'h000, 0, 0, 8'hA5, 0, 10'h005));
        tbl.push_back(mk(0, 10'h005, 0, 10'h000, 0, 0, 8'hA5, 0, 10'h005));
        // Port 1 drops req during WAIT; response still delivered, then idle.
        tbl.push_back(mk(0, 10'h000, 1, 10'h0C3, 0, 0, 8'hA5, 1, 10'h0C3));
        tbl.push_back(mk(0, 10'h000, 0, 10'h0C3, 0, 1, 8'h3C, 1, 10'h0C3));
        tbl.push_back(mk(0, 10'h000, 0, 10'h0C3, 0, 0, 8'h3C, 0, 10'h0C3));
        tbl.push_back(mk(0, 10'h000, 0, 10'h0C3, 0, 0, 8'h3C, 0, 10'h0C3));
        tbl.push_back(mk(0, 10'h000, 0, 10'h0C3, 0, 0, 8'h3C, 0, 10'h0C3));

        repeat (2) @(posedge clk);
        #1;
        chk_main("reset", 0, 0, 8'h00, 0, 10'h000);
        check("reset.busy_3", 32'(busy_3), 32'd0);
        check("reset.rdata_3", 32'(rdata_3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            req0 = tbl[i].r0; addr0 = tbl[i].a0; req1 = tbl[i].r1; addr1 = tbl[i].a1;
            @(posedge clk);
            #1;
            chk_main($sformatf("v%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].rd, tbl[i].bsy, tbl[i].ma);
        end

        // Back-to-back on port 0: addresses 0..3, rvalid0 every 3 cycles.
        mem[10'h001] = 8'h01;
        prev_d = 8'h3C;
        for (int c = 0; c < 12; c++) begin
            req0 = (c % 3) != 2; addr0 = 10'(c / 3);
            @(posedge clk);
            #1;
            if ((c % 3) == 1) prev_d = 8'(c / 3);
            chk_main($sformatf("b2b%0d", c), (c % 3) == 1, 0, prev_d, (c % 3) != 2, 10'(c / 3));
        end
        req0 = 0;

        // Reset during WAIT after a port-0 grant; pointer must return to port 0.
        addr0 = 10'h002; req0 = 1;
        @(posedge clk);
        #1;
        chk_main("mid.grant", 0, 0, 8'h03, 1, 10'h002);
        #2 rst_n = 1'b0;
        #1;
        chk_main("mid.async", 0, 0, 8'h00, 0, 10'h000);
        req1 = 1; addr1 = 10'h003;
        @(posedge clk);
        #1;
        chk_main("mid.held", 0, 0, 8'h00, 0, 10'h000);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_main("mid.regrant", 0, 0, 8'h00, 1, 10'h002);
        @(posedge clk);
        #1;
        chk_main("mid.resp", 1, 0, 8'h02, 1, 10'h002);
        req0 = 0; req1 = 0;
        @(posedge clk);
        #1;
        chk_main("mid.idle", 0, 0, 8'h02, 0, 10'h002);

        // WAIT_CYCLES=3: capture on the 3rd edge after the grant, never the stale word.
        req0_3 = 1; addr0_3 = 10'h2A5;
        @(posedge clk);
        #1;
        check("w3.grant.mem_addr", 32'(mem_addr_3), 32'h2A5);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("w3.c%0d.rvalid0", c), 32'(rvalid0_3), 32'(c == 3));
            check($sformatf("w3.c%0d.rvalid1", c), 32'(rvalid1_3), 32'd0);
            check($sformatf("w3.c%0d.busy", c), 32'(busy_3), 32'(c < 4));
            check($sformatf("w3.c%0d.rdata", c), 32'(rdata_3), (c >= 3) ? 32'h5C : 32'h00);
            if (c == 3) req0_3 = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
